// File: rtl/mem_port_arbiter.sv
// Memory-bus arbiter between fetch (F) and execute (X) requesters with an in-order ID FIFO for response routing.
// Define MEM_ARB_FIXED_PRIO_EN to make X win every unlocked tie; default build is round-robin.
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int REQ_W           = 1 + DATA_W/8 + DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [REQ_W-1:0]  f_req_data,
    output logic              f_resp_valid,
    input  logic              f_resp_ready,
    output logic [DATA_W-1:0] f_resp_data,
    input  logic              x_req_valid,
    output logic              x_req_ready,
    input  logic [REQ_W-1:0]  x_req_data,
    output logic              x_resp_valid,
    input  logic              x_resp_ready,
    output logic [DATA_W-1:0] x_resp_data,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic [REQ_W-1:0]  m_req_data,
    input  logic              m_resp_valid,
    output logic              m_resp_ready,
    input  logic [DATA_W-1:0] m_resp_data
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic ID_F = 1'b0;
    localparam logic ID_X = 1'b1;

    typedef enum logic [1:0] {
        ARB_OPEN   = 2'd0,
        ARB_LOCK_F = 2'd1,
        ARB_LOCK_X = 2'd2
    } arb_state_e;

    arb_state_e state_q, state_d;

    logic [MAX_OUTSTANDING-1:0] id_fifo_q;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;

    logic grant_x;
    logic req_hs;
    logic pop;
    logic empty;
    logic full;
    logic head_x;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic rr_last_q, rr_last_d;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Lock FSM: holds the grant on a requester whose request the bus has not yet taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (m_req_valid && !m_req_ready) begin
            state_d = grant_x ? ARB_LOCK_X : ARB_LOCK_F;
        end else if (req_hs) begin
            state_d = ARB_OPEN;
        end
    end

    always_comb begin
        grant_x = ID_F;
        unique case (state_q)
            ARB_LOCK_F: grant_x = ID_F;
            ARB_LOCK_X: grant_x = ID_X;
            default: begin
                if (x_req_valid && !f_req_valid) begin
                    grant_x = ID_X;
                end else if (x_req_valid && f_req_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                    grant_x = ID_X;
`else
                    grant_x = (rr_last_q == ID_F);
`endif
                end
            end
        endcase
    end

    // Request path: pure mux, no added latency; every valid/ready is forced low during reset.
    assign m_req_data  = grant_x ? x_req_data : f_req_data;
    assign m_req_valid = rst && (grant_x ? x_req_valid : f_req_valid) && !full;
    assign f_req_ready = rst && !grant_x && m_req_ready && !full;
    assign x_req_ready = rst && grant_x && m_req_ready && !full;
    assign req_hs      = m_req_valid && m_req_ready;

    // Response path: routed by the FIFO head; a beat with nothing outstanding is sunk.
    assign empty        = (count_q == '0);
    assign head_x       = id_fifo_q[rd_ptr_q];
    assign m_resp_ready = rst && (empty ? 1'b1 : (head_x ? x_resp_ready : f_resp_ready));
    assign f_resp_valid = rst && !empty && !head_x && m_resp_valid;
    assign x_resp_valid = rst && !empty && head_x && m_resp_valid;
    assign f_resp_data  = m_resp_data;
    assign x_resp_data  = m_resp_data;
    assign pop          = m_resp_valid && m_resp_ready && !empty;
    assign full         = (count_q == CNT_MAX) && !pop;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        unique case ({req_hs, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (req_hs) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // ID storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (req_hs) begin
            id_fifo_q[wr_ptr_q] <= grant_x;
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    assign rr_last_d = req_hs ? grant_x : rr_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q <= ID_F;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert (!(m_resp_valid && empty))
                else $warning("mem_port_arbiter: response beat with no outstanding request dropped");
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_mem_port_arbiter;

    localparam int MAXO = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int RW   = 1 + DW/8 + DW + AW;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          f_req_valid, f_req_ready, f_resp_valid, f_resp_ready;
    logic [RW-1:0] f_req_data;
    logic [DW-1:0] f_resp_data;
    logic          x_req_valid, x_req_ready, x_resp_valid, x_resp_ready;
    logic [RW-1:0] x_req_data;
    logic [DW-1:0] x_resp_data;
    logic          m_req_valid, m_req_ready, m_resp_valid, m_resp_ready;
    logic [RW-1:0] m_req_data;
    logic [DW-1:0] m_resp_data;

    int n_cmp;
    int n_fail;

    mem_port_arbiter #(
        .MAX_OUTSTANDING(MAXO),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_data(f_req_data),
        .f_resp_valid(f_resp_valid), .f_resp_ready(f_resp_ready), .f_resp_data(f_resp_data),
        .x_req_valid(x_req_valid), .x_req_ready(x_req_ready), .x_req_data(x_req_data),
        .x_resp_valid(x_resp_valid), .x_resp_ready(x_resp_ready), .x_resp_data(x_resp_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_data(m_req_data),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_data(m_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    // Reference model: outstanding IDs as a queue (0=F, 1=X), lock holder (-1 none), last granted ID.
    int mq[$];
    int m_lock;
    int m_rr;
    int e_gid;
    bit e_mvalid, e_fready, e_xready, e_mrespready, e_fvalid, e_xvalid, e_pop;
    logic [RW-1:0] e_mdata;

    function automatic logic [RW-1:0] mk_req(input logic [AW-1:0] addr);
        return {1'b0, 4'hF, 32'h0, addr};
    endfunction

    function void model_reset();
        mq.delete();
        m_lock = -1;
        m_rr   = 0;
    endfunction

    function void model_eval();
        bit nonempty;
        bit full;
        int head;
        nonempty = (mq.size() > 0);
        head     = nonempty ? mq[0] : -1;
        if (m_lock >= 0) e_gid = m_lock;
        else if (f_req_valid && !x_req_valid) e_gid = 0;
        else if (x_req_valid && !f_req_valid) e_gid = 1;
        else if (f_req_valid && x_req_valid) e_gid = FIXED ? 1 : ((m_rr == 0) ? 1 : 0);
        else e_gid = -1;
        e_mrespready = !nonempty || ((head == 0) ? f_resp_ready : x_resp_ready);
        e_pop        = nonempty && m_resp_valid && e_mrespready;
        full         = (mq.size() == MAXO) && !e_pop;
        e_mvalid     = ((e_gid == 0 && f_req_valid) || (e_gid == 1 && x_req_valid)) && !full;
        e_fready     = (e_gid == 0) && m_req_ready && !full;
        e_xready     = (e_gid == 1) && m_req_ready && !full;
        e_fvalid     = nonempty && (head == 0) && m_resp_valid;
        e_xvalid     = nonempty && (head == 1) && m_resp_valid;
        e_mdata      = (e_gid == 1) ? x_req_data : f_req_data;
    endfunction

    function void model_commit();
        if (e_pop) void'(mq.pop_front());
        if (e_mvalid && m_req_ready) begin
            mq.push_back(e_gid);
            m_rr   = e_gid;
            m_lock = -1;
        end else if (e_mvalid) begin
            m_lock = e_gid;
        end
    endfunction

    task automatic clear_inputs();
        f_req_valid = 0; x_req_valid = 0; m_req_ready = 0; m_resp_valid = 0;
        f_resp_ready = 0; x_resp_ready = 0;
        f_req_data = '0; x_req_data = '0; m_resp_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        f_req_valid = 1; x_req_valid = 1; m_req_ready = 1; m_resp_valid = 1;
        f_resp_ready = 1; x_resp_ready = 1;
        @(negedge clk);
        n_cmp++; if (f_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_f_req_ready got %b exp 0", f_req_ready); end
        n_cmp++; if (x_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_x_req_ready got %b exp 0", x_req_ready); end
        n_cmp++; if (m_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_req_valid got %b exp 0", m_req_valid); end
        n_cmp++; if (f_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_f_resp_valid got %b exp 0", f_resp_valid); end
        n_cmp++; if (x_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_x_resp_valid got %b exp 0", x_resp_valid); end
        n_cmp++; if (m_resp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_m_resp_ready got %b exp 0", m_resp_ready); end
        @(posedge clk); #1;
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_resp_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_m_resp_ready got %b exp 1", m_resp_ready); end
        n_cmp++; if (m_req_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_m_req_valid got %b exp 0", m_req_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_fetch();
        do_reset();
        f_req_valid = 1; f_req_data = mk_req(32'h100); m_req_ready = 1;
        @(negedge clk);
        n_cmp++; if (m_req_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_m_req_valid got %b exp 1", m_req_valid); end
        n_cmp++; if (m_req_data[AW-1:0] !== 32'h100) begin n_fail++; $display("FAIL fetch_addr got %h exp 100", m_req_data[AW-1:0]); end
        n_cmp++; if (f_req_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_f_req_ready got %b exp 1", f_req_ready); end
        @(posedge clk); #1;
        f_req_valid = 0; m_req_ready = 0;
        m_resp_valid = 1; m_resp_data = 32'hDEADBEEF; f_resp_ready = 1;
        @(negedge clk);
        n_cmp++; if (f_resp_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_resp_valid got %b exp 1", f_resp_valid); end
        n_cmp++; if (f_resp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_resp_data got %h exp deadbeef", f_resp_data); end
        n_cmp++; if (x_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_x_resp_valid got %b exp 0", x_resp_valid); end
        n_cmp++; if (m_resp_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_m_resp_ready got %b exp 1", m_resp_ready); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_arbitration();
        bit exp_x;
        do_reset();
        f_req_valid = 1; f_req_data = mk_req(32'h200);
        x_req_valid = 1; x_req_data = mk_req(32'h300);
        m_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_x = FIXED ? 1'b1 : (i % 2 == 0);
            @(negedge clk);
            n_cmp++; if (x_req_ready !== exp_x) begin n_fail++; $display("FAIL arb_x_ready[%0d] got %b exp %b", i, x_req_ready, exp_x); end
            n_cmp++; if (f_req_ready !== !exp_x) begin n_fail++; $display("FAIL arb_f_ready[%0d] got %b exp %b", i, f_req_ready, !exp_x); end
            n_cmp++; if (m_req_data[AW-1:0] !== (exp_x ? 32'h300 : 32'h200)) begin
                n_fail++; $display("FAIL arb_addr[%0d] got %h exp %h", i, m_req_data[AW-1:0], exp_x ? 32'h300 : 32'h200);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_lock_stall();
        do_reset();
        x_req_valid = 1; x_req_data = mk_req(32'h400); m_req_ready = 1;
        @(negedge clk);
        n_cmp++; if (x_req_ready !== 1'b1) begin n_fail++; $display("FAIL lock_prime_x_ready got %b exp 1", x_req_ready); end
        @(posedge clk); #1;
        x_req_data = mk_req(32'h404); m_req_ready = 0;
        @(negedge clk);
        n_cmp++; if (m_req_valid !== 1'b1) begin n_fail++; $display("FAIL lock_m_req_valid got %b exp 1", m_req_valid); end
        n_cmp++; if (x_req_ready !== 1'b0) begin n_fail++; $display("FAIL lock_x_ready got %b exp 0", x_req_ready); end
        @(posedge clk); #1;
        f_req_valid = 1; f_req_data = mk_req(32'h500);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (f_req_ready !== 1'b0) begin n_fail++; $display("FAIL lock_f_ready[%0d] got %b exp 0", i, f_req_ready); end
            n_cmp++; if (m_req_valid !== 1'b1) begin n_fail++; $display("FAIL lock_hold_valid[%0d] got %b exp 1", i, m_req_valid); end
            n_cmp++; if (m_req_data[AW-1:0] !== 32'h404) begin n_fail++; $display("FAIL lock_hold_addr[%0d] got %h exp 404", i, m_req_data[AW-1:0]); end
            @(posedge clk); #1;
        end
        m_req_ready = 1;
        @(negedge clk);
        n_cmp++; if (x_req_ready !== 1'b1) begin n_fail++; $display("FAIL lock_release_x_ready got %b exp 1", x_req_ready); end
        n_cmp++; if (f_req_ready !== 1'b0) begin n_fail++; $display("FAIL lock_release_f_ready got %b exp 0", f_req_ready); end
        n_cmp++; if (m_req_data[AW-1:0] !== 32'h404) begin n_fail++; $display("FAIL lock_release_addr got %h exp 404", m_req_data[AW-1:0]); end
        @(posedge clk); #1;
        x_req_valid = 0;
        @(negedge clk);
        n_cmp++; if (f_req_ready !== 1'b1) begin n_fail++; $display("FAIL lock_after_f_ready got %b exp 1", f_req_ready); end
        n_cmp++; if (m_req_data[AW-1:0] !== 32'h500) begin n_fail++; $display("FAIL lock_after_addr got %h exp 500", m_req_data[AW-1:0]); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_full();
        int ids[4];
        int order[4];
        ids = '{0, 1, 1, 0};
        order = '{1, 1, 0, 1};
        do_reset();
        m_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            f_req_valid = (ids[i] == 0); x_req_valid = (ids[i] == 1);
            f_req_data = mk_req(32'h600 + 32'(i * 4)); x_req_data = f_req_data;
            @(negedge clk);
            n_cmp++; if (((ids[i] == 0) ? f_req_ready : x_req_ready) !== 1'b1) begin
                n_fail++; $display("FAIL full_fill_ready[%0d] got %b exp 1", i, (ids[i] == 0) ? f_req_ready : x_req_ready);
            end
            @(posedge clk); #1;
        end
        f_req_valid = 1; x_req_valid = 0;
        @(negedge clk);
        n_cmp++; if (f_req_ready !== 1'b0) begin n_fail++; $display("FAIL full_fifth_ready got %b exp 0", f_req_ready); end
        n_cmp++; if (m_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_fifth_valid got %b exp 0", m_req_valid); end
        @(posedge clk); #1;
        f_req_valid = 0; x_req_valid = 1; x_req_data = mk_req(32'h700);
        m_resp_valid = 1; m_resp_data = 32'h11110000; f_resp_ready = 1; x_resp_ready = 1;
        @(negedge clk);
        n_cmp++; if (f_resp_valid !== 1'b1) begin n_fail++; $display("FAIL full_swap_f_resp got %b exp 1", f_resp_valid); end
        n_cmp++; if (x_resp_valid !== 1'b0) begin n_fail++; $display("FAIL full_swap_x_resp got %b exp 0", x_resp_valid); end
        n_cmp++; if (m_resp_ready !== 1'b1) begin n_fail++; $display("FAIL full_swap_m_resp_ready got %b exp 1", m_resp_ready); end
        n_cmp++; if (x_req_ready !== 1'b1) begin n_fail++; $display("FAIL full_swap_x_req_ready got %b exp 1", x_req_ready); end
        @(posedge clk); #1;
        x_req_valid = 0; m_resp_valid = 0; f_req_valid = 1;
        @(negedge clk);
        n_cmp++; if (f_req_ready !== 1'b0) begin n_fail++; $display("FAIL full_still_full got %b exp 0", f_req_ready); end
        @(posedge clk); #1;
        f_req_valid = 0;
        for (int k = 0; k < 4; k++) begin
            m_resp_valid = 1; m_resp_data = 32'h22220000 + 32'(k);
            @(negedge clk);
            n_cmp++; if (x_resp_valid !== (order[k] == 1)) begin n_fail++; $display("FAIL full_drain_x[%0d] got %b exp %b", k, x_resp_valid, order[k] == 1); end
            n_cmp++; if (f_resp_valid !== (order[k] == 0)) begin n_fail++; $display("FAIL full_drain_f[%0d] got %b exp %b", k, f_resp_valid, order[k] == 0); end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_resp_backpressure();
        do_reset();
        x_req_valid = 1; x_req_data = mk_req(32'h800); m_req_ready = 1;
        @(negedge clk);
        n_cmp++; if (x_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_x_req_ready got %b exp 1", x_req_ready); end
        @(posedge clk); #1;
        x_req_valid = 0;
        m_resp_valid = 1; m_resp_data = 32'hCAFE0001; x_resp_ready = 0; f_resp_ready = 1;
        f_req_valid = 1; f_req_data = mk_req(32'h900);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (x_resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_x_resp_valid[%0d] got %b exp 1", i, x_resp_valid); end
            n_cmp++; if (f_resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_f_resp_valid[%0d] got %b exp 0", i, f_resp_valid); end
            n_cmp++; if (m_resp_ready !== 1'b0) begin n_fail++; $display("FAIL bp_m_resp_ready[%0d] got %b exp 0", i, m_resp_ready); end
            n_cmp++; if (f_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_f_req_ready[%0d] got %b exp 1", i, f_req_ready); end
            @(posedge clk); #1;
        end
        f_req_valid = 0; x_resp_ready = 1;
        @(negedge clk);
        n_cmp++; if (m_resp_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", m_resp_ready); end
        n_cmp++; if (x_resp_data !== 32'hCAFE0001) begin n_fail++; $display("FAIL bp_x_resp_data got %h exp cafe0001", x_resp_data); end
        @(posedge clk); #1;
        m_resp_data = 32'hCAFE0002;
        @(negedge clk);
        n_cmp++; if (f_resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_f_resp got %b exp 1", f_resp_valid); end
        n_cmp++; if (x_resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_next_x_resp got %b exp 0", x_resp_valid); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        m_req_ready = 1;
        f_req_valid = 1; f_req_data = mk_req(32'hA00);
        @(posedge clk); #1;
        f_req_valid = 0; x_req_valid = 1; x_req_data = mk_req(32'hB00);
        @(posedge clk); #1;
        rst = 0;
        f_req_valid = 1; x_req_valid = 1; m_resp_valid = 1; f_resp_ready = 1; x_resp_ready = 1;
        @(negedge clk);
        n_cmp++; if (f_req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_f_req_ready got %b exp 0", f_req_ready); end
        n_cmp++; if (x_req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_x_req_ready got %b exp 0", x_req_ready); end
        n_cmp++; if (m_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_m_req_valid got %b exp 0", m_req_valid); end
        n_cmp++; if (f_resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_f_resp_valid got %b exp 0", f_resp_valid); end
        n_cmp++; if (x_resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_x_resp_valid got %b exp 0", x_resp_valid); end
        n_cmp++; if (m_resp_ready !== 1'b0) begin n_fail++; $display("FAIL mid_m_resp_ready got %b exp 0", m_resp_ready); end
        @(posedge clk); #1;
        rst = 1;
        f_req_valid = 0; x_req_valid = 0; m_req_ready = 0;
        f_resp_ready = 0; x_resp_ready = 0; m_resp_valid = 1; m_resp_data = 32'h5A5A5A5A;
        @(negedge clk);
        n_cmp++; if (m_resp_ready !== 1'b1) begin n_fail++; $display("FAIL stray_m_resp_ready got %b exp 1", m_resp_ready); end
        n_cmp++; if (f_resp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_f_resp_valid got %b exp 0", f_resp_valid); end
        n_cmp++; if (x_resp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_x_resp_valid got %b exp 0", x_resp_valid); end
        @(posedge clk); #1;
        m_resp_valid = 0; m_req_ready = 1; f_req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (f_req_ready !== (i < 4)) begin n_fail++; $display("FAIL mid_refill_ready[%0d] got %b exp %b", i, f_req_ready, i < 4); end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [95:0] r;
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            f_req_valid  = ($urandom_range(0, 9) < 6);
            x_req_valid  = ($urandom_range(0, 9) < 6);
            r = {$urandom(), $urandom(), $urandom()}; f_req_data = r[RW-1:0];
            r = {$urandom(), $urandom(), $urandom()}; x_req_data = r[RW-1:0];
            m_req_ready  = ($urandom_range(0, 9) < 7);
            m_resp_valid = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            m_resp_data  = $urandom();
            f_resp_ready = ($urandom_range(0, 9) < 7);
            x_resp_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            model_eval();
            n_cmp++; if (m_req_valid !== e_mvalid) begin n_fail++; $display("FAIL rnd_m_req_valid c=%0d got %b exp %b", c, m_req_valid, e_mvalid); end
            n_cmp++; if (m_resp_ready !== e_mrespready) begin n_fail++; $display("FAIL rnd_m_resp_ready c=%0d got %b exp %b", c, m_resp_ready, e_mrespready); end
            n_cmp++; if (f_resp_valid !== e_fvalid) begin n_fail++; $display("FAIL rnd_f_resp_valid c=%0d got %b exp %b", c, f_resp_valid, e_fvalid); end
            n_cmp++; if (x_resp_valid !== e_xvalid) begin n_fail++; $display("FAIL rnd_x_resp_valid c=%0d got %b exp %b", c, x_resp_valid, e_xvalid); end
            if (f_req_valid) begin
                n_cmp++; if (f_req_ready !== e_fready) begin n_fail++; $display("FAIL rnd_f_req_ready c=%0d got %b exp %b", c, f_req_ready, e_fready); end
            end
            if (x_req_valid) begin
                n_cmp++; if (x_req_ready !== e_xready) begin n_fail++; $display("FAIL rnd_x_req_ready c=%0d got %b exp %b", c, x_req_ready, e_xready); end
            end
            if (e_mvalid) begin
                n_cmp++; if (m_req_data !== e_mdata) begin n_fail++; $display("FAIL rnd_m_req_data c=%0d got %h exp %h", c, m_req_data, e_mdata); end
            end
            if (e_fvalid) begin
                n_cmp++; if (f_resp_data !== m_resp_data) begin n_fail++; $display("FAIL rnd_f_resp_data c=%0d got %h exp %h", c, f_resp_data, m_resp_data); end
            end
            if (e_xvalid) begin
                n_cmp++; if (x_resp_data !== m_resp_data) begin n_fail++; $display("FAIL rnd_x_resp_data c=%0d got %h exp %h", c, x_resp_data, m_resp_data); end
            end
            model_commit();
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_single_fetch();
        test_arbitration();
        test_lock_stall();
        test_full();
        test_resp_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
